sobel_stream: RTL and testbench
===============================

# sobel_stream

Self-contained streaming Sobel edge detector that replaces the fixed box-blur and Sobel chain with one parametrised block. It accepts a raster grayscale pixel stream with valid/ready handshaking and tracks row and column internally. It holds two line buffers and builds a 3x3 window. It emits one output pixel per input pixel, in a run-time selectable mode: magnitude, |gx|, |gy| or binary threshold. It sits between the rgb2gray stage and the output packer in the UART image path.

## Interface
- WIDTH_P, 8: pixel width in bits.
- LINE_W_P, 640: pixels per line (≥3).
- FRAME_H_P, 480: lines per frame (≥3).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- valid_i  in  1  input pixel valid.
- ready_o  out  1  input pixel accepted when valid_i & ready_o.
- data_i  in  WIDTH_P  grayscale pixel, raster order.
- mode_i  in  2  0 = |gx|+|gy|, 1 = |gx|, 2 = |gy|, 3 = threshold.
- thresh_i  in  WIDTH_P  threshold for mode 3.
- valid_o  out  1  output pixel valid.
- ready_i  in  1  downstream ready.
- data_o  out  WIDTH_P  result pixel.
- user_o  out  1  high with the first output pixel of a frame.
- last_o  out  1  high with the last output pixel of a line.

## Operation
- **Counters**
  - col (0..LINE_W_P-1) and row (0..FRAME_H_P-1) advance on each accept.
  - col wraps and increments row; row wraps to 0 after the last line.
- **Line buffers**
  - Two LINE_W_P x WIDTH_P memories, addressed by col, with synchronous read enabled only on accept.
  - Buffer A returns row-1 and buffer B returns row-2 at this col.
  - On accept: A[col] <= data_i, B[col] <= A[col] (old value).
- **Window**
  - 3x3 shift register, shifted left on accept.
  - The new right column is {B, A, data_i}, top to bottom.
  - The window's bottom-right pixel is always the just-accepted pixel.
- **Output position**
  - The output for accept (row, col) is the window centred at (row-1, col-1).
  - If row<2 or col<2, data_o = 0 (border).
  - Result: output image equals input size, shifted one row and one column, with a zero border.
- **Arithmetic**
  - gx = (p02 + 2p12 + p22) - (p00 + 2p10 + p20), signed, WIDTH_P+4 bits.
  - gy = (p20 + 2p21 + p22) - (p00 + 2p01 + p02), signed, WIDTH_P+4 bits.
  - Take absolute values, then select by mode: sum, |gx| or |gy|.
  - Saturate to 2^WIDTH_P-1.
  - Mode 3: data_o = (|gx|+|gy| saturated ≥ thresh_i) ? all-ones : 0. Border pixels stay 0.
- **Mode capture**
  - mode_i and thresh_i are registered only on accept of row 0 / col 0.
  - They stay constant for the whole frame; mid-frame changes take effect next frame.
- **Markers**
  - user_o is set with the output of accept (0,0).
  - last_o is set with the output of any accept where col = LINE_W_P-1.
  - Both are qualified by valid_o.
- **Reset**
  - Outputs after reset: valid_o=0, data_o=0, user_o=0, last_o=0. ready_o reflects ready_i | ~valid_o, so it is 1 once valid_o is cleared.
  - Also cleared: col, row, window, internal valid; captured mode becomes 0 and threshold becomes 0.
  - Line buffer contents are not reset; the border rule guarantees stale data is never visible.
  - Reset mid-frame: the next accepted pixel is treated as (0,0).

## Timing
- Two-stage pipeline:
  - s1: line buffer read data and window registers.
  - s2: registered data_o, valid_o, user_o, last_o.
- Advance enable en = ~valid_o | ready_i; ready_o = en (combinational, no combinational path from valid_i).
- Latency: accept at cycle t gives valid_o at t+2 with ready_i held high. Throughput is 1 pixel/cycle.
- While ready_i=0 and valid_o=1, all outputs hold stable and nothing is accepted.
- A bubble on valid_i propagates as valid_o=0; the pipeline does not stall on input gaps.
- Exactly one output per accepted input, in order; none dropped, none duplicated.

## Configuration
- SOBEL_STREAM_THRESH_EN
  - Defined: mode 3 threshold logic and the thresh_i capture register are built.
  - Undefined: mode 3 behaves exactly as mode 0, thresh_i is ignored, and no threshold register or comparator is built.

## Test plan
All scenarios use LINE_W_P=4, FRAME_H_P=4, WIDTH_P=8.
- **Flat image:** all pixels 100, mode 0 -> 16 outputs, all 0; user_o on output 0; last_o on outputs 3, 7, 11, 15.
- **Vertical edge:** every row is 0,0,255,255.
  - mode 1 -> rows 2-3, cols 2-3 = 255 (gx=1020, saturated); all other outputs 0.
  - mode 2 -> all 0.
- **Backpressure:** random 50% ready_i and random valid_i gaps on the edge image -> output sequence identical to the free-running case; outputs stable whenever valid_o & ~ready_i.
- **Threshold (macro on):** mode 3 on the edge image.
  - thresh_i=128 -> 255 at rows 2-3, cols 2-3, else 0.
  - thresh_i=0 -> all non-border pixels 255.
- **Mode change mid-frame:** mode 1 at frame start, switch to mode 2 after pixel 5 -> frame 1 fully mode 1; frame 2 fully mode 2.
- **Reset mid-frame:** pulse rst_i after 6 accepts -> valid_o=0 immediately; the next accepted pixel's output carries user_o=1; 16 further outputs match a clean frame.

Source files
------------

// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector with two line buffers, valid/ready handshake and frame/line markers.
// Optional macro SOBEL_STREAM_THRESH_EN builds the mode-3 binary threshold; otherwise mode 3 behaves as mode 0.
module sobel_stream #(
  parameter int WIDTH_P   = 8,
  parameter int LINE_W_P  = 640,
  parameter int FRAME_H_P = 480
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic [WIDTH_P-1:0] data_i,
  input  logic [1:0]         mode_i,
  input  logic [WIDTH_P-1:0] thresh_i,
  output logic               valid_o,
  input  logic               ready_i,
  output logic [WIDTH_P-1:0] data_o,
  output logic               user_o,
  output logic               last_o
);

  localparam int CW = $clog2(LINE_W_P);
  localparam int RW = $clog2(FRAME_H_P);
  localparam int GW = WIDTH_P + 4;
  localparam logic [CW-1:0] COL_LAST = CW'(LINE_W_P - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(FRAME_H_P - 1);

  typedef enum logic [1:0] {
    MODE_SUM    = 2'd0,
    MODE_GX     = 2'd1,
    MODE_GY     = 2'd2,
    MODE_THRESH = 2'd3
  } mode_e;

  logic               w_en;
  logic               w_acc;
  logic               w_first;
  logic [CW-1:0]      r_col;
  logic [RW-1:0]      r_row;
  logic [WIDTH_P-1:0] r_line_a [LINE_W_P];
  logic [WIDTH_P-1:0] r_line_b [LINE_W_P];
  logic [WIDTH_P-1:0] r_p00, r_p01, r_p02;
  logic [WIDTH_P-1:0] r_p10, r_p11, r_p12;
  logic [WIDTH_P-1:0] r_p20, r_p21, r_p22;
  logic               r_s1_valid;
  logic               r_s1_border;
  logic               r_s1_first;
  logic               r_s1_last;
  mode_e              r_mode;
  logic               r_valid_o;
  logic [WIDTH_P-1:0] r_data_o;
  logic               r_user_o;
  logic               r_last_o;

  assign w_en    = ~r_valid_o | ready_i;
  assign w_acc   = valid_i & w_en;
  assign w_first = (r_row == '0) && (r_col == '0);
  assign ready_o = w_en;

  // Line buffers hold no reset: the zero border hides any stale contents.
  always_ff @(posedge clk_i) begin
    if (w_acc) begin
      r_line_a[r_col] <= data_i;
      r_line_b[r_col] <= r_line_a[r_col];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_col       <= '0;
      r_row       <= '0;
      r_p00       <= '0; r_p01 <= '0; r_p02 <= '0;
      r_p10       <= '0; r_p11 <= '0; r_p12 <= '0;
      r_p20       <= '0; r_p21 <= '0; r_p22 <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_first  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_mode      <= MODE_SUM;
    end else begin
      if (w_en) begin
        r_s1_valid <= valid_i;
      end
      if (w_acc) begin
        // Right column is the synchronous line-buffer read plus the live pixel.
        r_p00 <= r_p01; r_p01 <= r_p02; r_p02 <= r_line_b[r_col];
        r_p10 <= r_p11; r_p11 <= r_p12; r_p12 <= r_line_a[r_col];
        r_p20 <= r_p21; r_p21 <= r_p22; r_p22 <= data_i;
        r_s1_border <= (r_row < RW'(2)) || (r_col < CW'(2));
        r_s1_first  <= w_first;
        r_s1_last   <= (r_col == COL_LAST);
        if (w_first) begin
          r_mode <= mode_e'(mode_i);
        end
        if (r_col == COL_LAST) begin
          r_col <= '0;
          r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
    end
  end

`ifdef SOBEL_STREAM_THRESH_EN
  logic [WIDTH_P-1:0] r_thresh;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_thresh <= '0;
    end else if (w_acc && w_first) begin
      r_thresh <= thresh_i;
    end
  end
`else
  logic w_unused_thresh;
  assign w_unused_thresh = ^thresh_i;
`endif

  function automatic logic signed [GW-1:0] ext(input logic [WIDTH_P-1:0] p);
    return $signed({4'b0000, p});
  endfunction

  function automatic logic [WIDTH_P-1:0] sat(input logic [GW:0] v);
    return (|v[GW:WIDTH_P]) ? '1 : v[WIDTH_P-1:0];
  endfunction

  logic signed [GW-1:0] w_gx;
  logic signed [GW-1:0] w_gy;
  logic [GW-1:0]        w_ax;
  logic [GW-1:0]        w_ay;
  logic [GW:0]          w_sum;
  logic [GW:0]          w_sel;
  logic [WIDTH_P-1:0]   w_result;

  assign w_gx  = (ext(r_p02) + (ext(r_p12) <<< 1) + ext(r_p22))
               - (ext(r_p00) + (ext(r_p10) <<< 1) + ext(r_p20));
  assign w_gy  = (ext(r_p20) + (ext(r_p21) <<< 1) + ext(r_p22))
               - (ext(r_p00) + (ext(r_p01) <<< 1) + ext(r_p02));
  assign w_ax  = w_gx[GW-1] ? $unsigned(-w_gx) : $unsigned(w_gx);
  assign w_ay  = w_gy[GW-1] ? $unsigned(-w_gy) : $unsigned(w_gy);
  assign w_sum = {1'b0, w_ax} + {1'b0, w_ay};

  always_comb begin
    w_sel    = w_sum;
    w_result = '0;
    case (r_mode)
      MODE_GX: w_sel = {1'b0, w_ax};
      MODE_GY: w_sel = {1'b0, w_ay};
      default: w_sel = w_sum;
    endcase
    if (!r_s1_border) begin
      w_result = sat(w_sel);
`ifdef SOBEL_STREAM_THRESH_EN
      if (r_mode == MODE_THRESH) begin
        w_result = (sat(w_sum) >= r_thresh) ? '1 : '0;
      end
`endif
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_o <= 1'b0;
      r_data_o  <= '0;
      r_user_o  <= 1'b0;
      r_last_o  <= 1'b0;
    end else if (w_en) begin
      r_valid_o <= r_s1_valid;
      r_data_o  <= r_s1_valid ? w_result : '0;
      r_user_o  <= r_s1_valid & r_s1_first;
      r_last_o  <= r_s1_valid & r_s1_last;
    end
  end

  assign valid_o = r_valid_o;
  assign data_o  = r_data_o;
  assign user_o  = r_user_o;
  assign last_o  = r_last_o;

endmodule

// File: tb/tb_sobel_stream.sv
// Self-checking bench for sobel_stream on a 4x4 frame against a kernel-convolution reference model.
module tb_sobel_stream;

  localparam int NPIX = 16;
  typedef int img_t [NPIX];

  logic       clk = 1'b0;
  logic       rst;
  logic       valid_i;
  logic       ready_o;
  logic [7:0] data_i;
  logic [1:0] mode_i;
  logic [7:0] thresh_i;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] data_o;
  logic       user_o;
  logic       last_o;

  int checks = 0;
  int errors = 0;
  int q_out[$];
  int exp_q[$];
  bit bp_en = 1'b0;
  bit rdy_hold_lo = 1'b0;
  int stall_viol = 0;

  always #5 clk = ~clk;

  sobel_stream #(
    .WIDTH_P  (8),
    .LINE_W_P (4),
    .FRAME_H_P(4)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .data_i  (data_i),
    .mode_i  (mode_i),
    .thresh_i(thresh_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .data_o  (data_o),
    .user_o  (user_o),
    .last_o  (last_o)
  );

  initial begin
    ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      ready_i = rdy_hold_lo ? 1'b0 : (bp_en ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Output collector; also records any output change while stalled.
  logic [10:0] held;
  bit          stalled = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stalled = 1'b0;
    end else begin
      if (stalled && ({valid_o, user_o, last_o, data_o} !== held)) stall_viol++;
      if (valid_o && ready_i) q_out.push_back({22'd0, user_o, last_o, data_o});
      stalled = valid_o && !ready_i;
      held    = {valid_o, user_o, last_o, data_o};
    end
  end

  task automatic make_img(input int kind, output img_t m);
    for (int i = 0; i < NPIX; i++) begin
      case (kind)
        0:       m[i] = 100;
        1:       m[i] = ((i % 4) >= 2) ? 255 : 0;
        default: m[i] = int'($urandom_range(0, 255));
      endcase
    end
  endtask

  // Reference: explicit 3x3 kernel convolution over the image, output at (r,c) centred on (r-1,c-1).
  task automatic model_frame(input img_t img, input int mode, input int th);
    int kx[3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
    int ky[3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};
    int gx, gy, a, b, s, v;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        v = 0;
        if (r >= 2 && c >= 2) begin
          gx = 0;
          gy = 0;
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
              gx += kx[i][j] * img[(r - 2 + i) * 4 + (c - 2 + j)];
              gy += ky[i][j] * img[(r - 2 + i) * 4 + (c - 2 + j)];
            end
          a = (gx < 0) ? -gx : gx;
          b = (gy < 0) ? -gy : gy;
          s = (a + b > 255) ? 255 : a + b;
          case (mode)
            1:       v = (a > 255) ? 255 : a;
            2:       v = (b > 255) ? 255 : b;
`ifdef SOBEL_STREAM_THRESH_EN
            3:       v = (s >= th) ? 255 : 0;
`endif
            default: v = s;
          endcase
        end
        exp_q.push_back(((r == 0 && c == 0) ? 512 : 0) + ((c == 3) ? 256 : 0) + v);
      end
    end
  endtask

  task automatic drive_pixels(input img_t img, input int n, input int m0, input int m1,
                              input int sw, input int th, input bit gaps);
    bit acc;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          valid_i = 1'b0;
          @(posedge clk);
          #1;
        end
      end
      valid_i  = 1'b1;
      data_i   = 8'(img[i]);
      mode_i   = 2'((i < sw) ? m0 : m1);
      thresh_i = 8'(th);
      acc = 1'b0;
      t   = 0;
      while (!acc && t < 200) begin
        @(negedge clk);
        acc = ready_o;
        @(posedge clk);
        #1;
        t++;
      end
    end
    valid_i = 1'b0;
  endtask

  task automatic wait_outputs(input int n);
    int t = 0;
    while (q_out.size() < n && t < 2000) begin
      @(posedge clk);
      t++;
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    valid_i = 1'b0;
    rst     = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    q_out.delete();
    exp_q.delete();
  endtask

  task automatic test_reset();
    rdy_hold_lo = 1'b1;
    do_reset();
    checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", valid_o); end
    checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL rst_data got %h want 00", data_o); end
    checks++; if (user_o !== 1'b0) begin errors++; $display("FAIL rst_user got %b want 0", user_o); end
    checks++; if (last_o !== 1'b0) begin errors++; $display("FAIL rst_last got %b want 0", last_o); end
    checks++; if (ready_o !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", ready_o); end
    rdy_hold_lo = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_flat();
    img_t img;
    do_reset();
    make_img(0, img);
    model_frame(img, 0, 0);
    drive_pixels(img, NPIX, 0, 0, 0, 0, 1'b0);
    wait_outputs(NPIX);
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL flat_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL flat_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  task automatic test_vertical_edge();
    img_t img;
    make_img(1, img);
    for (int m = 1; m <= 2; m++) begin
      do_reset();
      model_frame(img, m, 0);
      drive_pixels(img, NPIX, m, m, 0, 0, 1'b0);
      wait_outputs(NPIX);
      checks++;
      if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL edge_m%0d_count got %0d want %0d", m, q_out.size(), exp_q.size()); end
      for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
        checks++;
        if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL edge_m%0d_px%0d got %03h want %03h", m, k, q_out[k], exp_q[k]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    img_t img;
    int   m;
    do_reset();
    for (int f = 0; f < 4; f++) begin
      make_img(2, img);
      m = (f == 3) ? 0 : int'($urandom_range(0, 2));
      model_frame(img, m, 0);
      drive_pixels(img, NPIX, m, m, 0, 0, 1'b0);
    end
    wait_outputs(4 * NPIX);
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  task automatic test_backpressure();
    img_t img;
    do_reset();
    stall_viol = 0;
    bp_en = 1'b1;
    make_img(1, img);
    model_frame(img, 1, 0);
    drive_pixels(img, NPIX, 1, 1, 0, 0, 1'b1);
    make_img(2, img);
    model_frame(img, 0, 0);
    drive_pixels(img, NPIX, 0, 0, 0, 0, 1'b1);
    wait_outputs(2 * NPIX);
    bp_en = 1'b0;
    checks++;
    if (stall_viol != 0) begin errors++; $display("FAIL bp_stable got %0d changes want 0", stall_viol); end
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL bp_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL bp_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  task automatic test_threshold();
    img_t img;
    do_reset();
    make_img(1, img);
    model_frame(img, 3, 128);
    drive_pixels(img, NPIX, 3, 3, 0, 128, 1'b0);
    model_frame(img, 3, 0);
    drive_pixels(img, NPIX, 3, 3, 0, 0, 1'b0);
    wait_outputs(2 * NPIX);
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL thr_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL thr_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  task automatic test_mode_change();
    img_t img;
    do_reset();
    make_img(2, img);
    model_frame(img, 1, 0);
    drive_pixels(img, NPIX, 1, 2, 6, 0, 1'b0);
    make_img(2, img);
    model_frame(img, 2, 0);
    drive_pixels(img, NPIX, 2, 2, 0, 0, 1'b0);
    wait_outputs(2 * NPIX);
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL mchg_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL mchg_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  task automatic test_reset_mid();
    img_t img;
    do_reset();
    make_img(2, img);
    drive_pixels(img, 6, 0, 0, 0, 0, 1'b0);
    rst = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", valid_o); end
    #1;
    rst = 1'b0;
    q_out.delete();
    exp_q.delete();
    make_img(2, img);
    model_frame(img, 0, 0);
    drive_pixels(img, NPIX, 0, 0, 0, 0, 1'b0);
    wait_outputs(NPIX);
    checks++;
    if (q_out.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count got %0d want %0d", q_out.size(), exp_q.size()); end
    for (int k = 0; k < exp_q.size() && k < q_out.size(); k++) begin
      checks++;
      if (q_out[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_px%0d got %03h want %03h", k, q_out[k], exp_q[k]); end
    end
  endtask

  initial begin
    rst      = 1'b1;
    valid_i  = 1'b0;
    data_i   = '0;
    mode_i   = '0;
    thresh_i = '0;
    test_reset();
    test_flat();
    test_vertical_edge();
    test_back_to_back();
    test_backpressure();
    test_threshold();
    test_mode_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
